mdu_iter: RTL and testbench
===========================

# mdu_iter

Iterative multiply/divide unit for the EX stage of the five-stage pipeline core, replacing single-cycle arithmetic for MULT/MULTU/DIV/DIVU. Parametrised in operand width. It computes a double-width product or a quotient/remainder pair into HI/LO over WIDTH iteration cycles. It holds the pipeline through the EX stall request to CTRL and supports cancellation when the instruction is flushed.

## Interface
Parameters:
- WIDTH, 32, operand width; hi/lo are each WIDTH bits; must be ≥ 4.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous and active-high.
- start  in  1  request a new operation; sampled only in IDLE.
- op  in  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- src_a  in  WIDTH  multiplicand / dividend.
- src_b  in  WIDTH  multiplier / divisor.
- cancel  in  1  abort the in-flight operation (pipeline flush).
- busy  out  1  high in any state other than IDLE.
- stallreq  out  1  EX stall request to CTRL.
- result_valid  out  1  one-cycle pulse when hi/lo take a new result.
- hi  out  WIDTH  product upper half / remainder.
- lo  out  WIDTH  product lower half / quotient.

## Operation
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE:
  - start=1 and cancel=0: latch op, magnitudes of src_a/src_b (for signed ops) and the result sign flags.
  - Go to MUL (op[1]=0) or DIV (op[1]=1); iteration counter = 0.
- MUL: shift-add, one multiplier bit per cycle. Exactly WIDTH cycles, then DONE.
- DIV: restoring division, one quotient bit per cycle. Exactly WIDTH cycles, then DONE.
- DONE:
  - Apply sign correction and write hi/lo.
  - Pulse result_valid, then return to IDLE.
- Arithmetic rules:
  - MULT/MULTU: {hi,lo} = full 2·WIDTH product, signed or unsigned.
  - DIV: quotient truncates toward zero; quotient negative iff operand signs differ; remainder takes the dividend's sign.
  - Signed overflow (MIN / −1): lo = MIN, hi = 0, with no exception.
  - Divide by zero (both DIV and DIVU): lo = all ones, hi = src_a as latched. Same latency as a normal divide.
- hi/lo change only in DONE or on reset; they hold their value otherwise.
- start while busy is ignored; no queueing.
- cancel:
  - In MUL/DIV/DONE: next state is IDLE, no result_valid, hi/lo unchanged.
  - cancel has priority over start in the same cycle.
- Reset: state IDLE, counter 0, hi=0, lo=0, result_valid=0, busy=0. rst overrides cancel and start.

## Timing
- Start accepted at edge T0 → MUL/DIV during cycles T0+1 … T0+WIDTH → DONE at T0+WIDTH+1.
- At the end of DONE, hi/lo are updated. result_valid is high during DONE, combinationally with the final values on hi/lo.
- Total latency from the start cycle to the result_valid cycle is WIDTH+1 cycles (33 for WIDTH=32).
- stallreq = ~rst & ((IDLE & start & ~cancel) | MUL | DIV).
  - It is combinational, so the requesting instruction stalls in its first EX cycle.
  - It is low in DONE, so the instruction leaves EX with the result available.
  - Held high for exactly WIDTH+1 cycles per operation.
- busy is registered: high from T0+1 through the DONE cycle; low the cycle after DONE or after cancel.
- Back-to-back operation: a new start is accepted in the first IDLE cycle after DONE. The minimum issue interval is WIDTH+2 cycles.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF (WIDTH=32) → after 33 cycles, result_valid pulses once with hi=0xFFFFFFFE, lo=0x00000001; stallreq high for exactly 33 cycles.
- MULT −3 × 7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULT 0x80000000 × 0x80000000 → hi=0x40000000, lo=0.
- DIV −7 / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100 / 7 → lo=14, hi=2. DIV 7 / −2 → lo=0xFFFFFFFD, hi=1.
- Corner cases:
  - DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
  - DIVU 5 / 0 → lo=0xFFFFFFFF, hi=5, same 33-cycle latency.
- Start DIVU, then assert cancel 10 cycles later together with a new start → no result_valid, busy low next cycle, hi/lo keep their prior values, new start ignored. A start in the following IDLE cycle is accepted normally.
- Assert rst mid-MUL at cycle 15 → next cycle busy=0, stallreq=0, hi=lo=0, no result_valid pulse. Repeat the test with WIDTH=8: MULTU 0xFF × 0xFF → hi=0xFE, lo=0x01 after 9 cycles.

Source files
------------

// File: rtl/mdu_iter_if.sv
// rtl/mdu_iter_if.sv - EX-stage multiply/divide request and result bundle
interface mdu_iter_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             cancel;
  logic             busy;
  logic             stallreq;
  logic             result_valid;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, src_a, src_b, cancel,
    input  busy, stallreq, result_valid, hi, lo
  );

  modport slave (
    input  start, op, src_a, src_b, cancel,
    output busy, stallreq, result_valid, hi, lo
  );
endinterface

// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - iterative shift-add multiplier / restoring divider into HI/LO
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input logic       clk,
  input logic       rst,
  mdu_iter_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] a_raw;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;
  logic             neg_q;
  logic             neg_r;
  logic             is_mul;
  logic             div_zero;

  logic             signed_op;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag_in;
  logic [WIDTH-1:0] b_mag_in;
  logic             accept;
  logic             last_iter;

  assign signed_op = ~bus.op[0];
  assign a_neg     = signed_op & bus.src_a[WIDTH-1];
  assign b_neg     = signed_op & bus.src_b[WIDTH-1];
  assign a_mag_in  = a_neg ? (~bus.src_a + 1'b1) : bus.src_a;
  assign b_mag_in  = b_neg ? (~bus.src_b + 1'b1) : bus.src_b;
  assign accept    = (state == S_IDLE) & bus.start & ~bus.cancel;
  assign last_iter = (cnt == CW'(WIDTH - 1));

  // Multiply: acc_lo starts as the multiplier and shifts out LSB-first while
  // the partial product shifts in from acc_hi.
  logic [WIDTH:0] mul_sum;
  assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, b_mag} : {(WIDTH+1){1'b0}});

  // Divide: acc_lo starts as the dividend and fills with quotient bits;
  // acc_hi holds the partial remainder.
  logic [WIDTH:0]   rem_sh;
  logic             div_borrow;
  logic [WIDTH-1:0] div_rem;
  assign rem_sh     = {acc_hi, acc_lo[WIDTH-1]};
  assign div_borrow = rem_sh < {1'b0, b_mag};
  assign div_rem    = rem_sh[WIDTH-1:0] - b_mag;

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   fin_hi;
  logic [WIDTH-1:0]   fin_lo;
  assign prod = neg_q ? (~{acc_hi, acc_lo} + 1'b1) : {acc_hi, acc_lo};

  always_comb begin
    fin_hi = hi_r;
    fin_lo = lo_r;
    if (is_mul) begin
      fin_hi = prod[2*WIDTH-1:WIDTH];
      fin_lo = prod[WIDTH-1:0];
    end else if (div_zero) begin
      fin_hi = a_raw;
      fin_lo = {WIDTH{1'b1}};
    end else begin
      fin_hi = neg_r ? (~acc_hi + 1'b1) : acc_hi;
      fin_lo = neg_q ? (~acc_lo + 1'b1) : acc_lo;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      b_mag    <= '0;
      a_raw    <= '0;
      hi_r     <= '0;
      lo_r     <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      is_mul   <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            acc_hi   <= '0;
            acc_lo   <= a_mag_in;
            b_mag    <= b_mag_in;
            a_raw    <= bus.src_a;
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
            is_mul   <= ~bus.op[1];
            div_zero <= (bus.src_b == '0);
            cnt      <= '0;
            state    <= bus.op[1] ? S_DIV : S_MUL;
          end
        end
        S_MUL: begin
          if (bus.cancel) begin
            state <= S_IDLE;
          end else begin
            acc_hi <= mul_sum[WIDTH:1];
            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
            cnt    <= cnt + 1'b1;
            if (last_iter) state <= S_DONE;
          end
        end
        S_DIV: begin
          if (bus.cancel) begin
            state <= S_IDLE;
          end else begin
            acc_hi <= div_borrow ? rem_sh[WIDTH-1:0] : div_rem;
            acc_lo <= {acc_lo[WIDTH-2:0], ~div_borrow};
            cnt    <= cnt + 1'b1;
            if (last_iter) state <= S_DONE;
          end
        end
        default: begin
          if (!bus.cancel) begin
            hi_r <= fin_hi;
            lo_r <= fin_lo;
          end
          state <= S_IDLE;
        end
      endcase
    end
  end

  // The result is visible on hi/lo during DONE itself, then held by hi_r/lo_r.
  assign bus.result_valid = (state == S_DONE) & ~bus.cancel & ~rst;
  assign bus.hi           = bus.result_valid ? fin_hi : hi_r;
  assign bus.lo           = bus.result_valid ? fin_lo : lo_r;
  assign bus.busy         = (state != S_IDLE);
  assign bus.stallreq     = ~rst & (accept | (state == S_MUL) | (state == S_DIV));
endmodule

// File: tb/tb_mdu_iter.sv
// tb/tb_mdu_iter.sv - directed self-checking bench for mdu_iter at WIDTH 32 and 8
module tb_mdu_iter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mdu_iter_if #(.WIDTH(32)) b32 ();
  mdu_iter_if #(.WIDTH(8))  b8 ();

  mdu_iter #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(b32));
  mdu_iter #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(b8));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    int lat;
    int stl;
    logic found;
    logic [31:0] gh;
    logic [31:0] gl;
    @(negedge clk);
    b32.start = 1'b1; b32.op = op; b32.src_a = a; b32.src_b = b;
    #1;
    stl = int'(b32.stallreq);
    lat = 0; found = 1'b0; gh = '0; gl = '0;
    @(negedge clk);
    b32.start = 1'b0;
    while (!found && lat < 100) begin
      #1;
      lat++;
      if (b32.stallreq) stl++;
      if (b32.result_valid) begin
        found = 1'b1; gh = b32.hi; gl = b32.lo;
      end else begin
        @(negedge clk);
      end
    end
    check({tag, "_valid"}, 64'(found), 64'd1);
    check({tag, "_lat"}, 64'(lat), 64'd33);
    check({tag, "_stall"}, 64'(stl), 64'd33);
    check({tag, "_hi"}, 64'(gh), 64'(eh));
    check({tag, "_lo"}, 64'(gl), 64'(el));
    @(negedge clk);
    #1;
    check({tag, "_rv_off"}, 64'(b32.result_valid), 64'd0);
    check({tag, "_idle"}, 64'(b32.busy), 64'd0);
    check({tag, "_hi_hold"}, 64'(b32.hi), 64'(eh));
    check({tag, "_lo_hold"}, 64'(b32.lo), 64'(el));
  endtask

  initial begin
    int lat;
    int stl;
    int pulses;
    logic found;
    b32.start = 1'b0; b32.op = 2'b00; b32.src_a = '0; b32.src_b = '0; b32.cancel = 1'b0;
    b8.start = 1'b0;  b8.op = 2'b00;  b8.src_a = '0;  b8.src_b = '0;  b8.cancel = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", 64'(b32.busy), 64'd0);
    check("rst_hi", 64'(b32.hi), 64'd0);
    check("rst_lo", 64'(b32.lo), 64'd0);
    check("rst_rv", 64'(b32.result_valid), 64'd0);
    check("rst_stall", 64'(b32.stallreq), 64'd0);
    rst = 1'b0;

    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult_m3x7", 2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("mult_min2", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0);
    run_op("div_m7d2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu_100d7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14);
    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
    run_op("divu_zero", 2'b11, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
    run_op("div_7dm2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);

    // Cancel ten cycles into a DIVU, with a competing start in the same cycle.
    pulses = 0;
    @(negedge clk);
    b32.start = 1'b1; b32.op = 2'b11; b32.src_a = 32'd1000; b32.src_b = 32'd3;
    @(negedge clk);
    b32.start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      #1;
      if (b32.result_valid) pulses++;
      @(negedge clk);
    end
    b32.cancel = 1'b1; b32.start = 1'b1; b32.op = 2'b01; b32.src_a = 32'd9; b32.src_b = 32'd9;
    #1;
    if (b32.result_valid) pulses++;
    @(negedge clk);
    b32.cancel = 1'b0; b32.start = 1'b0;
    #1;
    check("cancel_busy", 64'(b32.busy), 64'd0);
    check("cancel_hi", 64'(b32.hi), 64'd1);
    check("cancel_lo", 64'(b32.lo), 64'hFFFF_FFFD);
    @(negedge clk);
    #1;
    check("cancel_start_ignored", 64'(b32.busy), 64'd0);
    check("cancel_no_rv", 64'(pulses), 64'd0);
    run_op("after_cancel", 2'b11, 32'd1000, 32'd3, 32'd1, 32'd333);

    // Reset in the middle of a multiply.
    pulses = 0;
    @(negedge clk);
    b32.start = 1'b1; b32.op = 2'b01; b32.src_a = 32'h1234_5678; b32.src_b = 32'd3;
    @(negedge clk);
    b32.start = 1'b0;
    repeat (14) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_stall", 64'(b32.stallreq), 64'd0);
    check("midrst_rv", 64'(b32.result_valid), 64'd0);
    @(negedge clk);
    #1;
    check("midrst_busy", 64'(b32.busy), 64'd0);
    check("midrst_hi", 64'(b32.hi), 64'd0);
    check("midrst_lo", 64'(b32.lo), 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (b32.result_valid) pulses++;
    end
    check("midrst_no_rv", 64'(pulses), 64'd0);

    // Narrow instance: MULTU 0xFF x 0xFF over 9 cycles.
    @(negedge clk);
    b8.start = 1'b1; b8.op = 2'b01; b8.src_a = 8'hFF; b8.src_b = 8'hFF;
    #1;
    stl = int'(b8.stallreq);
    lat = 0; found = 1'b0;
    @(negedge clk);
    b8.start = 1'b0;
    while (!found && lat < 40) begin
      #1;
      lat++;
      if (b8.stallreq) stl++;
      if (b8.result_valid) begin
        found = 1'b1;
        check("w8_hi", 64'(b8.hi), 64'hFE);
        check("w8_lo", 64'(b8.lo), 64'h01);
      end else begin
        @(negedge clk);
      end
    end
    check("w8_valid", 64'(found), 64'd1);
    check("w8_lat", 64'(lat), 64'd9);
    check("w8_stall", 64'(stl), 64'd9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
